fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage and IF/ID pipeline register directly upstream of the main decoder. Holds the PC and issues word requests to instruction memory over a request/acknowledge handshake. Presents the captured instruction, pre-sliced into `op`/`shamt`/`funct`, to decode. Redirects on a decoded jump (`JumpD`) and absorbs decode stalls with a one-entry hold buffer.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  byte address of requested word (PC)
- `imem_ack`  in  1  `imem_rdata` valid this cycle for the current request
- `imem_rdata`  in  32  instruction word
- `stall_d`  in  1  decode cannot accept a new instruction this cycle
- `jump_d`  in  1  `JumpD` from the main decoder for the instruction in `instr_d`
- `instr_d`  out  32  IF/ID instruction
- `pc_plus4_d`  out  32  address of `instr_d` + 4
- `instr_valid_d`  out  1  `instr_d` holds a live instruction
- `op_d` / `shamt_d` / `funct_d`  out  6/5/6  `instr_d[31:26]` / `[10:6]` / `[5:0]`
- `fetch_cnt`, `bubble_cnt`  out  32 each  present only with `FETCH_PERF_CNT_EN`

## Operation
- FSM states: `S_FETCH` (`imem_req`=1, `imem_addr`=PC), `S_HOLD` (`imem_req`=0, hold buffer full). `imem_req` forced 0 while `rst`=1.
- `imem_ack` is honoured only in `S_FETCH`; an ack in `S_HOLD` is ignored.
- Load rule: IF/ID loads when `!instr_valid_d || !stall_d`.
- Load source: hold buffer if full, else `imem_rdata` on ack. With no source, IF/ID loads a bubble: `instr_valid_d`=0, `instr_d`=NOP 32'h0.
- Ack while IF/ID loads from memory: PC += 4 and state stays `S_FETCH`.
- Ack while IF/ID cannot load: word and PC+4 go to the hold buffer, PC += 4, go to `S_HOLD`.
- `S_HOLD` with the load rule true: buffer drains into IF/ID, go to `S_FETCH`.
- Jump taken = `instr_valid_d && jump_d && !stall_d`. The jump:
  - sets PC to `{pc_plus4_d[31:28], instr_d[25:0], 2'b00}`;
  - flushes IF/ID to a bubble and empties the hold buffer;
  - discards any same-cycle ack and enters `S_FETCH`.
- Jump taken outranks ack, hold drain and stall.
- PC arithmetic is modulo 2^32. Bits [1:0] are always 0.

## Timing
- Reset values:
  - PC = `RESET_PC`, state `S_FETCH`, hold buffer empty;
  - `instr_d` = 0, `pc_plus4_d` = 0, `instr_valid_d` = 0, counters 0.
- First `imem_req` in the first cycle with `rst`=0.
- Latency: ack in cycle N → `instr_valid_d`=1 with that word in N+1. Zero-wait memory sustains one instruction per cycle.
- Jump taken in cycle N → `imem_addr` = target and `instr_valid_d`=0 in N+1. Jump penalty is one bubble.
- `rst` asserted mid-operation overrides everything in that cycle. All in-flight state is discarded.
- Outputs `op_d`/`shamt_d`/`funct_d` are pure slices of `instr_d`, with no added delay.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_cnt` increments on every accepted ack;
  - `bubble_cnt` increments on every cycle IF/ID loads a bubble, including flushes;
  - both counters wrap at 2^32 and reset to 0.
- Undefined: both ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants `OP_J`=6'b000010, `OP_ORI`=6'b001101, `OP_LUI`=6'b001111, `OP_RTYPE`=6'b000000;
  - `NOP`=32'h0;
  - fetch state enum `fetch_state_t`.
- One sub-module `if_id_reg` holds `instr_d`, `pc_plus4_d` and `instr_valid_d`, with load/flush inputs. The FSM, PC and hold buffer stay in `fetch_unit`.

## Test plan
- Reset release, zero-wait memory returning `addr` as data → `imem_addr` 0,4,8; `instr_d` 0,4,8 one cycle later; `instr_valid_d` stays 1.
- `stall_d`=1 for 3 cycles with an ack on the first → one request accepted, `S_HOLD`, `imem_req`=0; `instr_d` unchanged; buffered word appears the cycle after `stall_d` drops.
- `instr_d`=32'h0800_0040 at `pc_plus4_d`=32'h1000_0008 with `jump_d`=1 → next `imem_addr`=32'h1000_0100 and one bubble.
- Jump taken while the hold buffer is full and `imem_ack`=1 → buffer and ack discarded; next valid instruction comes from the target.
- PC=32'hFFFF_FFFC ack → next `imem_addr`=0.
- `rst` pulsed mid-stream → all outputs reset values next cycle; with `FETCH_PERF_CNT_EN`, counters read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// cpu_pkg
// Shared opcodes, NOP encoding and fetch-stage state type.
// Revision: 1.0
//------------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'b000000;
    localparam logic [5:0]  OP_J     = 6'b000010;
    localparam logic [5:0]  OP_ORI   = 6'b001101;
    localparam logic [5:0]  OP_LUI   = 6'b001111;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } fetch_state_t;

    // Pseudo-direct J-type target: region bits come from the delay-slot PC.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] instr);
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register; flush or a source-less load inserts a NOP bubble.
// Revision: 1.0
//------------------------------------------------------------------------------
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        src_valid,
    input  logic [31:0] src_instr,
    input  logic [31:0] src_pc_plus4,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic        instr_valid_d
);

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_d       <= NOP;
            pc_plus4_d    <= 32'h0;
            instr_valid_d <= 1'b0;
        end else if (flush || (load && !src_valid)) begin
            instr_d       <= NOP;
            instr_valid_d <= 1'b0;
        end else if (load) begin
            instr_d       <= src_instr;
            pc_plus4_d    <= src_pc_plus4;
            instr_valid_d <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// fetch_unit
// PC, imem handshake FSM and one-entry hold buffer feeding the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt / bubble_cnt counters.
// Revision: 1.0
//------------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        jump_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic        instr_valid_d,
    output logic [5:0]  op_d,
    output logic [4:0]  shamt_d,
    output logic [5:0]  funct_d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt, w_pc_plus4;
    logic [31:0]  r_hold_instr, r_hold_pc4;
    logic         w_hold_we, w_load, w_jump, w_ack;
    logic         w_ifid_load, w_src_valid, w_bubble;
    logic [31:0]  w_src_instr, w_src_pc4;

    assign w_load     = !instr_valid_d || !stall_d;
    assign w_jump     = instr_valid_d && jump_d && !stall_d;
    assign w_ack      = (r_state == S_FETCH) && imem_ack;
    assign w_pc_plus4 = r_pc + 32'd4;

    assign imem_req  = !rst && (r_state == S_FETCH);
    assign imem_addr = r_pc;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hold_we   = 1'b0;
        w_ifid_load = 1'b0;
        w_src_valid = 1'b0;
        w_src_instr = NOP;
        w_src_pc4   = w_pc_plus4;
        // A taken jump wins over everything; if_id_reg sees it as flush.
        if (w_jump) begin
            w_pc_nxt    = jump_target(pc_plus4_d, instr_d);
            w_state_nxt = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_ack) begin
                        w_pc_nxt = w_pc_plus4;
                        if (w_load) begin
                            w_ifid_load = 1'b1;
                            w_src_valid = 1'b1;
                            w_src_instr = imem_rdata;
                        end else begin
                            w_hold_we   = 1'b1;
                            w_state_nxt = S_HOLD;
                        end
                    end else if (w_load) begin
                        w_ifid_load = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_load) begin
                        w_ifid_load = 1'b1;
                        w_src_valid = 1'b1;
                        w_src_instr = r_hold_instr;
                        w_src_pc4   = r_hold_pc4;
                        w_state_nxt = S_FETCH;
                    end
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

    assign w_bubble = w_jump || (w_ifid_load && !w_src_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= {RESET_PC[31:2], 2'b00};
            r_hold_instr <= NOP;
            r_hold_pc4   <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_hold_we) begin
                r_hold_instr <= imem_rdata;
                r_hold_pc4   <= w_pc_plus4;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (w_ifid_load),
        .flush        (w_jump),
        .src_valid    (w_src_valid),
        .src_instr    (w_src_instr),
        .src_pc_plus4 (w_src_pc4),
        .instr_d      (instr_d),
        .pc_plus4_d   (pc_plus4_d),
        .instr_valid_d(instr_valid_d)
    );

    assign op_d    = instr_d[31:26];
    assign shamt_d = instr_d[10:6];
    assign funct_d = instr_d[5:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt, r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt  <= 32'h0;
            r_bubble_cnt <= 32'h0;
        end else begin
            if (w_ack && !w_jump)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_bubble)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    logic w_unused;
    assign w_unused = w_bubble;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_fetch_unit
// Directed self-checking bench; a second instance starts at 32'hFFFF_FFFC.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, stall_d, jump_d, instr_valid_d;
    logic [31:0] imem_addr, imem_rdata, instr_d, pc_plus4_d;
    logic [5:0]  op_d, funct_d;
    logic [4:0]  shamt_d;
    logic        mem_override;
    logic [31:0] mem_word;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc4;
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_shamt;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, bubble_cnt, w_fcnt, w_bcnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem_override ? mem_word : imem_addr;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall_d      (stall_d),
        .jump_d       (jump_d),
        .instr_d      (instr_d),
        .pc_plus4_d   (pc_plus4_d),
        .instr_valid_d(instr_valid_d),
        .op_d         (op_d),
        .shamt_d      (shamt_d),
        .funct_d      (funct_d)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .bubble_cnt   (bubble_cnt)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (w_req),
        .imem_addr    (w_addr),
        .imem_ack     (1'b1),
        .imem_rdata   (w_addr),
        .stall_d      (1'b0),
        .jump_d       (1'b0),
        .instr_d      (w_instr),
        .pc_plus4_d   (w_pc4),
        .instr_valid_d(w_valid),
        .op_d         (w_op),
        .shamt_d      (w_shamt),
        .funct_d      (w_funct)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt    (w_fcnt),
        .bubble_cnt   (w_bcnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b1; stall_d = 1'b0; jump_d = 1'b0;
        mem_override = 1'b0; mem_word = 32'h0;
        step(); step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", instr_d); end
        checks++; if (pc_plus4_d !== 32'h0) begin errors++; $display("FAIL rst_pc4 got=%h exp=0", pc_plus4_d); end
        checks++; if (instr_valid_d !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", instr_valid_d); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_cnt !== 32'h0 || bubble_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt got=%h/%h exp=0/0", fetch_cnt, bubble_cnt); end
`endif
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
        checks++; if (w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_addr got=%h exp=fffffffc", w_addr); end
    endtask

    task automatic test_stream();
        step();
        checks++; if (instr_d !== 32'h0 || instr_valid_d !== 1'b1 || pc_plus4_d !== 32'h4) begin errors++; $display("FAIL stream0 got=%h/%b/%h exp=0/1/4", instr_d, instr_valid_d, pc_plus4_d); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL stream_addr4 got=%h exp=4", imem_addr); end
        checks++; if (w_addr !== 32'h0 || w_instr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h/%h exp=0/fffffffc", w_addr, w_instr); end
        step();
        checks++; if (instr_d !== 32'h4 || imem_addr !== 32'h8) begin errors++; $display("FAIL stream4 got=%h/%h exp=4/8", instr_d, imem_addr); end
        step();
        checks++; if (instr_d !== 32'h8 || imem_addr !== 32'hC || instr_valid_d !== 1'b1) begin errors++; $display("FAIL stream8 got=%h/%h/%b exp=8/c/1", instr_d, imem_addr, instr_valid_d); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_cnt !== 32'd3 || bubble_cnt !== 32'd0) begin errors++; $display("FAIL stream_cnt got=%0d/%0d exp=3/0", fetch_cnt, bubble_cnt); end
`endif
    endtask

    task automatic test_stall();
        stall_d = 1'b1;
        step();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h10 || instr_d !== 32'h8) begin errors++; $display("FAIL stall1 got=%b/%h/%h exp=0/10/8", imem_req, imem_addr, instr_d); end
        step();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h10 || instr_d !== 32'h8) begin errors++; $display("FAIL stall2 got=%b/%h/%h exp=0/10/8", imem_req, imem_addr, instr_d); end
        step();
        checks++; if (imem_addr !== 32'h10 || instr_d !== 32'h8 || instr_valid_d !== 1'b1) begin errors++; $display("FAIL stall3 got=%h/%h/%b exp=10/8/1", imem_addr, instr_d, instr_valid_d); end
        stall_d = 1'b0;
        step();
        checks++; if (instr_d !== 32'hC || pc_plus4_d !== 32'h10 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL drain got=%h/%h/%b/%h exp=c/10/1/10", instr_d, pc_plus4_d, imem_req, imem_addr); end
        step();
        checks++; if (instr_d !== 32'h10 || imem_addr !== 32'h14) begin errors++; $display("FAIL post_drain got=%h/%h exp=10/14", instr_d, imem_addr); end
    endtask

    task automatic test_jump();
        mem_override = 1'b1; mem_word = 32'h0BFF_FFFF;
        step();
        checks++; if (op_d !== 6'h02 || shamt_d !== 5'h1F || funct_d !== 6'h3F) begin errors++; $display("FAIL slice1 got=%h/%h/%h exp=02/1f/3f", op_d, shamt_d, funct_d); end
        mem_override = 1'b0; jump_d = 1'b1;
        step();
        checks++; if (imem_addr !== 32'h0FFF_FFFC || instr_valid_d !== 1'b0 || instr_d !== 32'h0) begin errors++; $display("FAIL jump1 got=%h/%b/%h exp=0ffffffc/0/0", imem_addr, instr_valid_d, instr_d); end
        jump_d = 1'b0;
        step();
        checks++; if (instr_d !== 32'h0FFF_FFFC || instr_valid_d !== 1'b1 || imem_addr !== 32'h1000_0000) begin errors++; $display("FAIL jump1_tgt got=%h/%b/%h exp=0ffffffc/1/10000000", instr_d, instr_valid_d, imem_addr); end
        step();
        mem_override = 1'b1; mem_word = 32'h0800_0040;
        step();
        checks++; if (instr_d !== 32'h0800_0040 || pc_plus4_d !== 32'h1000_0008) begin errors++; $display("FAIL jinstr got=%h/%h exp=08000040/10000008", instr_d, pc_plus4_d); end
        checks++; if (op_d !== 6'h02 || shamt_d !== 5'h01 || funct_d !== 6'h00) begin errors++; $display("FAIL slice2 got=%h/%h/%h exp=02/01/00", op_d, shamt_d, funct_d); end
        mem_override = 1'b0; jump_d = 1'b1;
        step();
        checks++; if (imem_addr !== 32'h1000_0100 || instr_valid_d !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL jump2 got=%h/%b/%b exp=10000100/0/1", imem_addr, instr_valid_d, imem_req); end
        jump_d = 1'b0;
        step();
        checks++; if (instr_d !== 32'h1000_0100 || instr_valid_d !== 1'b1 || imem_addr !== 32'h1000_0104) begin errors++; $display("FAIL jump2_tgt got=%h/%b/%h exp=10000100/1/10000104", instr_d, instr_valid_d, imem_addr); end
    endtask

    task automatic test_jump_hold();
        mem_override = 1'b1; mem_word = 32'h0800_0200;
        step();
        mem_override = 1'b0; stall_d = 1'b1;
        step();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h1000_010C || instr_d !== 32'h0800_0200) begin errors++; $display("FAIL jh_hold got=%b/%h/%h exp=0/1000010c/08000200", imem_req, imem_addr, instr_d); end
        stall_d = 1'b0; jump_d = 1'b1;
        step();
        checks++; if (imem_addr !== 32'h1000_0800 || instr_valid_d !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL jh_jump got=%h/%b/%b exp=10000800/0/1", imem_addr, instr_valid_d, imem_req); end
        jump_d = 1'b0;
        step();
        checks++; if (instr_d !== 32'h1000_0800 || instr_valid_d !== 1'b1 || pc_plus4_d !== 32'h1000_0804) begin errors++; $display("FAIL jh_tgt got=%h/%b/%h exp=10000800/1/10000804", instr_d, instr_valid_d, pc_plus4_d); end
    endtask

    task automatic test_reset_mid();
        step();
        rst = 1'b1;
        step();
        checks++; if (instr_d !== 32'h0 || pc_plus4_d !== 32'h0 || instr_valid_d !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL mid_rst got=%h/%h/%b/%b exp=0/0/0/0", instr_d, pc_plus4_d, instr_valid_d, imem_req); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_cnt !== 32'h0 || bubble_cnt !== 32'h0) begin errors++; $display("FAIL mid_rst_cnt got=%h/%h exp=0/0", fetch_cnt, bubble_cnt); end
`endif
        rst = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL mid_rst_pc got=%h/%b exp=0/1", imem_addr, imem_req); end
        step();
        checks++; if (instr_d !== 32'h0 || instr_valid_d !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL mid_rst_fetch got=%h/%b/%h exp=0/1/4", instr_d, instr_valid_d, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jump();
        test_jump_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
